// File: rtl/fdd_pkg.sv
// Shared constants, state type and cell-encoding helper for the floppy read-data generator.
package fdd_pkg;

  localparam int         DEF_HALF_CELL       = 56;
  localparam int         DEF_PULSE_W         = 14;
  localparam logic [7:0] DEF_GAP_MFM         = 8'h4E;
  localparam logic [7:0] DEF_GAP_FM          = 8'hFF;
  localparam logic [7:0] FM_MARK_CLK         = 8'hC7;
  localparam logic [2:0] MFM_MISSING_CLK_BIT = 3'd2;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Clock cell preceding data bit 'pos'; an MFM mark drops the clock before bit 2 (A1 -> 4489).
  function automatic logic enc_clock(input logic       is_mfm,
                                     input logic       mark,
                                     input logic       prev,
                                     input logic       d,
                                     input logic [2:0] pos);
    logic c;
    if (is_mfm) begin
      c = ~prev & ~d & ~(mark && (pos == MFM_MISSING_CLK_BIT));
    end else begin
      c = ~mark | FM_MARK_CLK[pos];
    end
    return c;
  endfunction

endpackage

// File: rtl/rdat_pulse_shaper.sv
// Turns a one-cycle strobe into an active-low rdat_n pulse of PULSE_W cycles, starting in the strobe cycle.
module rdat_pulse_shaper #(
  parameter int PULSE_W = 14
) (
  input  logic fclk,
  input  logic rst,
  input  logic clear,
  input  logic strobe,
  output logic rdat_n
);

  localparam int CW = $clog2(PULSE_W + 1);

  logic [CW-1:0] remain;

  // The strobe cycle itself is the first low cycle, so the counter covers the remaining PULSE_W-1.
  always_ff @(posedge fclk) begin
    if (rst || clear) begin
      remain <= '0;
    end else if (strobe) begin
      remain <= CW'(PULSE_W - 1);
    end else if (remain != '0) begin
      remain <= remain - CW'(1);
    end
  end

  assign rdat_n = ~(strobe | (remain != '0));

endmodule

// File: rtl/fdd_rdat_gen.sv
// Drive-side read-data generator: MFM/FM-encodes streamed bytes into rdat_n pulses for the VG93 read path.
module fdd_rdat_gen
  import fdd_pkg::*;
#(
  parameter int         HALF_CELL = DEF_HALF_CELL,
  parameter int         PULSE_W   = DEF_PULSE_W,
  parameter logic [7:0] GAP_MFM   = DEF_GAP_MFM,
  parameter logic [7:0] GAP_FM    = DEF_GAP_FM
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mfm,
  input  logic [7:0] byte_data,
  input  logic       byte_mark,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       rdat_n,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = $clog2(2 * HALF_CELL);

  state_t        state, state_nxt;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] win_max;
  logic [3:0]    win_idx;
  logic          mode_mfm;
  logic [7:0]    cur_byte;
  logic          cur_mark;
  logic          prev_bit;
  logic [7:0]    hold_byte;
  logic          hold_mark;
  logic          hold_full;
  logic          accept;
  logic          byte_end;
  logic [2:0]    bit_sel;
  logic          d_bit;
  logic          prev_in;
  logic          cell_bit;
  logic          strobe;

  assign accept   = byte_valid & byte_ready;
  assign win_max  = mode_mfm ? CW'(HALF_CELL - 1) : CW'(2 * HALF_CELL - 1);
  assign byte_end = (state == RUN) && (win_idx == 4'd15) && (win_cnt == win_max);

  always_ff @(posedge fclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if ((state == IDLE) && accept) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: byte_ready = enable;
      RUN: begin
        byte_ready = enable & ~hold_full;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Even windows carry the clock cell, odd windows the data cell, MSB first.
  always_comb begin
    bit_sel  = 3'd7 - win_idx[3:1];
    d_bit    = cur_byte[bit_sel];
    prev_in  = (bit_sel == 3'd7) ? prev_bit : cur_byte[bit_sel + 3'd1];
    cell_bit = win_idx[0] ? d_bit : enc_clock(mode_mfm, cur_mark, prev_in, d_bit, bit_sel);
    strobe   = (state == RUN) && (win_cnt == '0) && cell_bit;
  end

  always_ff @(posedge fclk) begin
    if (rst || !enable) begin
      win_cnt   <= '0;
      win_idx   <= '0;
      mode_mfm  <= 1'b1;
      cur_byte  <= '0;
      cur_mark  <= 1'b0;
      prev_bit  <= 1'b0;
      hold_byte <= '0;
      hold_mark <= 1'b0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        cur_byte <= byte_data;
        cur_mark <= byte_mark;
        mode_mfm <= mfm;
        win_cnt  <= '0;
        win_idx  <= '0;
      end
    end else begin
      if (win_cnt == win_max) begin
        win_cnt <= '0;
        win_idx <= win_idx + 4'd1;
      end else begin
        win_cnt <= win_cnt + CW'(1);
      end
      // Byte boundary uses the holding register as it stood before this cycle's accept.
      if (byte_end) begin
        prev_bit <= cur_byte[0];
        if (hold_full) begin
          cur_byte <= hold_byte;
          cur_mark <= hold_mark;
        end else begin
          cur_byte <= mode_mfm ? GAP_MFM : GAP_FM;
          cur_mark <= 1'b0;
          underrun <= 1'b1;
        end
      end
      if (accept) begin
        hold_byte <= byte_data;
        hold_mark <= byte_mark;
        hold_full <= 1'b1;
      end else if (byte_end) begin
        hold_full <= 1'b0;
      end
    end
  end

  rdat_pulse_shaper #(
    .PULSE_W(PULSE_W)
  ) u_shaper (
    .fclk  (fclk),
    .rst   (rst),
    .clear (~enable),
    .strobe(strobe),
    .rdat_n(rdat_n)
  );

endmodule
